// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      STOP
   } tx_state_t;

   localparam int   DEFAULT_DATA_W = 8;
   localparam int   FRAME_W        = DEFAULT_DATA_W + 2;
   localparam logic START_BIT      = 1'b0;
   localparam logic STOP_BIT       = 1'b1;
   localparam int   BIT_CNT_W      = $clog2(FRAME_W + 1);

   // Width of a counter that must reach frame_w inclusive
   function automatic int bit_cnt_width(input int frame_w);
      return $clog2(frame_w + 1);
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled, tick marks count 0.
module uart_baud_cnt #(
   parameter int CLK_DIV = 868
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       clr,
   output logic                       tick,
   output logic [$clog2(CLK_DIV)-1:0] count
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Next count: clear has priority, otherwise advance and wrap at the period end
   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en) begin
         if (count_reg == CNT_LAST) begin
            count_next = '0;
         end else begin
            count_next = count_reg + CNT_W'(1);
         end
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign tick  = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, frames it and paces the PISO
// load/shift strobes at the baud rate.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 868,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              load,
   output logic              shift,
   output logic [DATA_W+1:0] p_data,
   output logic              busy,
   output logic              tx_done
);

   localparam int FRAME_BITS = DATA_W + 2;
   localparam int CNT_BITS   = bit_cnt_width(FRAME_BITS);
   localparam int BAUD_W     = $clog2(CLK_DIV);

   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(FRAME_BITS);
   // The baud counter reads 2 in the first STOP cycle; leaving at CLK_DIV-2
   // makes the stop bit a full period when the next byte follows at once.
   localparam logic [BAUD_W-1:0]   STOP_END = BAUD_W'(CLK_DIV - 2);

   tx_state_t             state_reg;
   tx_state_t             state_next;
   logic [CNT_BITS-1:0]   bit_cnt_reg;
   logic [CNT_BITS-1:0]   bit_cnt_next;
   logic                  tx_ready_reg;
   logic                  load_reg;
   logic                  shift_reg;
   logic                  shift_next;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  done_next;
   logic [FRAME_BITS-1:0] p_data_reg;
   logic [FRAME_BITS-1:0] frame_word;
   logic                  handshake;
   logic                  baud_en;
   logic                  baud_clr;
   logic                  baud_tick;
   logic [BAUD_W-1:0]     baud_count;

   assign handshake = tx_valid && tx_ready_reg && (state_reg == IDLE);

   // Frame layout: start bit in bit 0, payload LSB-first, stop bit on top
   assign frame_word[0]            = START_BIT;
   assign frame_word[FRAME_BITS-1] = STOP_BIT;
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_frame
         assign frame_word[gi+1] = tx_data[gi];
      end
   endgenerate

   // The counter is held at 0 in IDLE so its tick lines up with LOAD, which
   // schedules the first shift for the following cycle.
   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (baud_en),
      .clr   (baud_clr),
      .tick  (baud_tick),
      .count (baud_count)
   );

   // Next-state, bit counter and strobe scheduling; strobes are registered,
   // so each one is decided a cycle ahead of when it appears.
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = 1'b0;
      done_next    = 1'b0;
      baud_en      = 1'b1;
      baud_clr     = 1'b0;
      case (state_reg)
         IDLE: begin
            baud_en      = 1'b0;
            baud_clr     = 1'b1;
            bit_cnt_next = '0;
            if (handshake) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            shift_next   = 1'b1;
            bit_cnt_next = CNT_BITS'(1);
            state_next   = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt_reg == LAST_BIT) begin
               state_next = STOP;
            end else if (baud_tick) begin
               shift_next   = 1'b1;
               bit_cnt_next = bit_cnt_reg + CNT_BITS'(1);
            end
         end
         STOP: begin
            if (baud_count == STOP_END) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters, registered outputs and captured frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         tx_ready_reg <= 1'b0;
         load_reg     <= 1'b0;
         shift_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         p_data_reg   <= '1;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         tx_ready_reg <= (state_next == IDLE);
         load_reg     <= (state_next == LOAD);
         shift_reg    <= shift_next;
         busy_reg     <= (state_next != IDLE);
         done_reg     <= done_next;
         if (handshake) begin
            p_data_reg <= frame_word;
         end
      end
   end

   assign tx_ready = tx_ready_reg;
   assign load     = load_reg;
   assign shift    = shift_reg;
   assign busy     = busy_reg;
   assign tx_done  = done_reg;
   assign p_data   = p_data_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl with a behavioural PISO on the serial side.
module tb_uart_tx_ctrl;

   localparam int D  = 4;
   localparam int DW = 8;
   localparam int FW = DW + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          load;
   logic          shift;
   logic [FW-1:0] p_data;
   logic          busy;
   logic          tx_done;

   uart_tx_ctrl #(
      .CLK_DIV (D),
      .DATA_W  (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .load     (load),
      .shift    (shift),
      .p_data   (p_data),
      .busy     (busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   // Behavioural PISO: registered serial output, zero fill, idle high
   logic [FW-1:0] piso_reg;
   logic          line;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         piso_reg <= '1;
         line     <= 1'b1;
      end else if (load) begin
         piso_reg <= p_data;
      end else if (shift) begin
         line     <= piso_reg[0];
         piso_reg <= {1'b0, piso_reg[FW-1:1]};
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state: event times derived from the handshake cycle
   int            ready_at   = 0;
   int            busy_from  = 0;
   int            busy_until = 0;
   int            load_at    = -1;
   int            done_at    = -1;
   bit            shift_due [int];
   logic          line_due  [int];
   logic [FW-1:0] exp_p      = '1;
   logic [FW-1:0] pending_frame = '1;
   logic          exp_line   = 1'b1;

   // Scoreboard of what the DUT actually produced
   int            sb_shifts     = 0;
   int            load_cnt      = 0;
   int            shift_cnt     = 0;
   int            done_cnt      = 0;
   int            hs_cnt        = 0;
   int            last_done_cyc = 0;
   int            sample_at     = -1;
   int            hs_cyc[$];
   int            shift_cyc[$];
   logic [FW-1:0] rx_bits   = '0;
   logic [FW-1:0] last_bits = '0;
   bit            line_low_seen = 1'b0;

   // Per-cycle comparison against the model, sampled on the falling edge
   initial begin : monitor
      logic exp_ready, exp_busy, exp_load, exp_shift, exp_done;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_tx_ready", 32'(tx_ready), 32'(0));
            check("rst_load", 32'(load), 32'(0));
            check("rst_shift", 32'(shift), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_tx_done", 32'(tx_done), 32'(0));
            check("rst_p_data", 32'(p_data), 32'(10'h3FF));
            check("rst_line", 32'(line), 32'(1));
            ready_at   = cyc + 2;
            busy_from  = 0;
            busy_until = 0;
            load_at    = -1;
            done_at    = -1;
            shift_due.delete();
            line_due.delete();
            exp_p      = '1;
            exp_line   = 1'b1;
            sb_shifts  = 0;
            sample_at  = -1;
            rx_bits    = '0;
         end else begin
            exp_ready = (cyc >= ready_at);
            exp_busy  = (cyc >= busy_from) && (cyc < busy_until);
            exp_load  = (cyc == load_at);
            exp_done  = (cyc == done_at);
            exp_shift = shift_due.exists(cyc);
            if (exp_shift) shift_due.delete(cyc);
            if (exp_load) exp_p = pending_frame;
            if (line_due.exists(cyc)) begin
               exp_line = line_due[cyc];
               line_due.delete(cyc);
            end
            check("tx_ready", 32'(tx_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(exp_busy));
            check("load", 32'(load), 32'(exp_load));
            check("shift", 32'(shift), 32'(exp_shift));
            check("tx_done", 32'(tx_done), 32'(exp_done));
            check("p_data", 32'(p_data), 32'(exp_p));
            check("line", 32'(line), 32'(exp_line));
            check("load_shift_overlap", 32'(load & shift), 32'(0));

            if (cyc == sample_at) rx_bits = {line, rx_bits[FW-1:1]};
            if (!line) line_low_seen = 1'b1;
            if (load) begin
               load_cnt++;
               sb_shifts = 0;
            end
            if (shift) begin
               shift_cnt++;
               sb_shifts++;
               shift_cyc.push_back(cyc);
               sample_at = cyc + 1;
            end
            if (tx_done) begin
               done_cnt++;
               last_done_cyc = cyc;
               last_bits     = rx_bits;
               check("shifts_per_frame", 32'(sb_shifts), 32'(FW));
            end

            if (tx_valid && exp_ready) begin
               pending_frame = {1'b1, tx_data, 1'b0};
               load_at    = cyc + 1;
               busy_from  = cyc + 1;
               busy_until = cyc + FW * D;
               ready_at   = cyc + FW * D;
               done_at    = cyc + FW * D;
               for (int k = 1; k <= FW; k++) begin
                  shift_due[cyc + 2 + (k - 1) * D] = 1'b1;
                  line_due[cyc + 3 + (k - 1) * D]  = pending_frame[k-1];
               end
               hs_cnt++;
               hs_cyc.push_back(cyc);
               $display("frame %0d: data=%02h accepted at cycle %0d", hs_cnt, tx_data, cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [DW-1:0] d);
      int n = 0;
      int base;
      while (!tx_ready && n < 100) begin
         step();
         n++;
      end
      base     = hs_cnt;
      tx_data  = d;
      tx_valid = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (hs_cnt == base && n < 100);
      tx_valid = 1'b0;
      check("handshake_seen", 32'(hs_cnt > base), 32'(1));
   endtask

   task automatic wait_done(input int base, input bit scramble);
      int n = 0;
      while (done_cnt <= base && n < 200) begin
         if (scramble) tx_data = DW'($urandom);
         step();
         n++;
      end
      check("done_seen", 32'(done_cnt > base), 32'(1));
   endtask

   typedef struct {
      logic [DW-1:0] data;
      int            gap;
      logic [FW-1:0] frame;
   } vec_t;

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   initial begin : stim
      vec_t vecs[6];
      int   base;
      int   bad;
      int   n;
      logic [DW-1:0] d;

      vecs[0] = '{8'hA5, 0, 10'h34A};
      vecs[1] = '{8'h00, 1, 10'h200};
      vecs[2] = '{8'hFF, 2, 10'h3FE};
      vecs[3] = '{8'h01, 0, 10'h202};
      vecs[4] = '{8'h80, 3, 10'h300};
      vecs[5] = '{8'h3C, 5, 10'h278};

      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("ready_after_reset", 32'(tx_ready), 32'(1));

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         base = done_cnt;
         send_byte(vecs[i].data);
         wait_done(base, 1'b0);
         check("vec_p_data", 32'(p_data), 32'(vecs[i].frame));
         check("vec_line_bits", 32'(last_bits), 32'(vecs[i].frame));
         check("vec_done_latency", 32'(last_done_cyc - hs_cyc[hs_cyc.size()-1]), 32'(FW * D));
         repeat (vecs[i].gap) step();
      end

      // Idle hold
      base = shift_cnt;
      n    = load_cnt;
      bad  = 0;
      line_low_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!tx_ready) bad++;
      end
      check("idle_ready_drops", 32'(bad), 32'(0));
      check("idle_shifts", 32'(shift_cnt - base), 32'(0));
      check("idle_loads", 32'(load_cnt - n), 32'(0));
      check("idle_line_low", 32'(line_low_seen), 32'(0));

      // Back-to-back with valid held high
      shift_cyc.delete();
      base     = hs_cnt;
      n        = done_cnt;
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      for (int i = 0; i < 200 && hs_cnt < base + 2; i++) begin
         step();
         if (hs_cnt == base + 1) tx_data = 8'hFF;
      end
      tx_valid = 1'b0;
      check("b2b_two_handshakes", 32'(hs_cnt - base), 32'(2));
      wait_done(n + 1, 1'b0);
      check("b2b_handshake_gap", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 32'(FW * D));
      check("b2b_shift_total", 32'(shift_cyc.size()), 32'(2 * FW));
      bad = 0;
      for (int i = 1; i < shift_cyc.size(); i++) begin
         if (shift_cyc[i] - shift_cyc[i-1] != D) bad++;
      end
      check("b2b_spacing_errors", 32'(bad), 32'(0));
      check("b2b_last_bits", 32'(last_bits), 32'(10'h3FE));

      // Data stability: tx_data scrambled every cycle after the handshake
      base = done_cnt;
      send_byte(8'h3C);
      wait_done(base, 1'b1);
      check("stable_p_data", 32'(p_data), 32'(10'h278));
      check("stable_line_bits", 32'(last_bits), 32'(10'h278));

      // Reset after the fifth shift pulse
      step();
      shift_cyc.delete();
      base = done_cnt;
      send_byte(8'h96);
      n = 0;
      while (shift_cyc.size() < 5 && n < 100) begin
         step();
         n++;
      end
      check("rst_mid_pulses_seen", 32'(shift_cyc.size()), 32'(5));
      rst_n = 1'b0;
      #1;
      check("abort_tx_ready", 32'(tx_ready), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_p_data", 32'(p_data), 32'(10'h3FF));
      check("abort_line", 32'(line), 32'(1));
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      check("abort_no_done", 32'(done_cnt - base), 32'(0));
      base = done_cnt;
      send_byte(8'h5A);
      wait_done(base, 1'b0);
      check("after_abort_bits", 32'(last_bits), 32'(10'h2B4));

      // Randomized frames with random gaps and scrambled tx_data
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) begin
            tx_data = DW'($urandom);
            step();
         end
         d    = DW'($urandom);
         base = done_cnt;
         send_byte(d);
         wait_done(base, 1'b1);
         check("rand_line_bits", 32'(last_bits), 32'({1'b1, d, 1'b0}));
      end

      repeat (5) step();
      check("frames_equal_dones", 32'(done_cnt), 32'(hs_cnt - 1));
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
